// File: rtl/fw_digest_check.sv
// fw_digest_check: streams a firmware image through a rotate-XOR digest and
// compares the result against a trusted signature held in boot ROM.
module fw_digest_check #(
    parameter logic [7:0]  INIT_DIGEST = 8'h5A,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] fw_len,
    input  logic [7:0] trusted_sig,
    input  logic [7:0] fw_data,
    input  logic       fw_valid,
    output logic       fw_ready,
    output logic       busy,
    output logic       done,
    output logic       firmware_valid,
    output logic       fw_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Timer value seen on the last idle cycle before expiry; the increment on
    // that cycle is what would take the timer to TIMEOUT-1.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 2);

    state_t     state, state_next;
    logic [7:0] digest;
    logic [7:0] len;
    logic [7:0] count;
    logic [7:0] timer;
    logic       xfer;
    logic       last_byte;
    logic       expired;

    assign xfer      = fw_valid & fw_ready;
    assign last_byte = (count == len - 8'd1);
    assign expired   = (timer == TIMER_LAST);

    // Next-state selection and state-decoded status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (fw_len != 8'd0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (xfer) begin
                    if (last_byte) begin
                        state_next = COMPARE;
                    end
                end else if (expired) begin
                    state_next = DONE;
                end
            end
            COMPARE: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, digest datapath, idle timer and registered verdict flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            fw_ready       <= 1'b0;
            digest         <= INIT_DIGEST;
            len            <= '0;
            count          <= '0;
            timer          <= '0;
            firmware_valid <= 1'b0;
            fw_error       <= 1'b0;
        end else begin
            state    <= state_next;
            fw_ready <= (state_next == LOAD);
            case (state)
                IDLE: begin
                    if (start) begin
                        firmware_valid <= 1'b0;
                        if (fw_len != 8'd0) begin
                            len      <= fw_len;
                            digest   <= INIT_DIGEST;
                            count    <= '0;
                            timer    <= '0;
                            fw_error <= 1'b0;
                        end else begin
                            fw_error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        digest <= {digest[6:0], digest[7]} ^ fw_data;
                        count  <= count + 8'd1;
                        timer  <= '0;
                    end else if (expired) begin
                        fw_error       <= 1'b1;
                        firmware_valid <= 1'b0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                COMPARE: begin
                    firmware_valid <= (digest == trusted_sig);
                    fw_error       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
